shift_arbiter: RTL

Shares one 32-bit barrel shifter (SLL/SRL/SRA, 5-bit amount) between two requesters: the ALU issue path and the load/store byte-alignment unit. Each requester uses a valid/ready handshake. The arbiter grants round-robin, drives the shared shifter combinationally, and captures the result in a one-entry output register tagged with the requester ID. It sits between the decode/issue logic and writeback, replacing the two private shifter instances.

---
 rtl/shift_pkg.sv | 25 ++
 rtl/shift_arbiter_if.sv | 40 ++++
 rtl/Shift.sv | 27 ++
 rtl/shift_arbiter.sv | 84 ++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared constants, function codes and helpers for the shift arbiter and its
// barrel shifter.
package shift_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    FT_SLL     = 2'b00,
    FT_SRL     = 2'b01,
    FT_ILLEGAL = 2'b10,
    FT_SRA     = 2'b11
  } ft_e;

  localparam logic REQ_ALU   = 1'b0;
  localparam logic REQ_ALIGN = 1'b1;

  // Lets one right-shifting datapath also serve left shifts.
  function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = x[DATA_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/shift_arbiter_if.sv
// Two valid/ready shift requesters plus the tagged result port of the
// shared shifter.
interface shift_arbiter_if;
  import shift_pkg::*;

  logic               req0_valid;
  logic               req0_ready;
  logic [SHAMT_W-1:0] req0_a;
  logic [DATA_W-1:0]  req0_b;
  logic [1:0]         req0_ft;

  logic               req1_valid;
  logic               req1_ready;
  logic [SHAMT_W-1:0] req1_a;
  logic [DATA_W-1:0]  req1_b;
  logic [1:0]         req1_ft;

  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_s;
  logic               out_id;
  logic               out_err;

  modport master (
    output req0_valid, req0_a, req0_b, req0_ft,
    output req1_valid, req1_a, req1_b, req1_ft,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_s, out_id, out_err
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ft,
    input  req1_valid, req1_a, req1_b, req1_ft,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_s, out_id, out_err
  );

endinterface

// File: rtl/Shift.sv
// Five-stage combinational barrel shifter: SLL, SRL, SRA by a 5-bit amount.
module Shift
  import shift_pkg::*;
(
  input  logic [SHAMT_W-1:0] A,
  input  logic [DATA_W-1:0]  B,
  input  logic [1:0]         FT,
  output logic [DATA_W-1:0]  S
);

  logic              left;
  logic              fill;
  logic [DATA_W-1:0] stage [SHAMT_W+1];

  // Left shifts run through the right-shift stages on a bit-reversed operand.
  assign left     = (FT == FT_SLL);
  assign fill     = (FT == FT_SRA) && B[DATA_W-1];
  assign stage[0] = left ? bit_reverse(B) : B;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    localparam int SH = 1 << k;
    assign stage[k+1] = A[k] ? {{SH{fill}}, stage[k][DATA_W-1:SH]} : stage[k];
  end

  assign S = left ? bit_reverse(stage[SHAMT_W]) : stage[SHAMT_W];

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin (or fixed-priority) arbiter sharing one barrel shifter between
// two requesters, with a one-entry tagged result register.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  shift_arbiter_if.slave  bus
);

  logic               grant0;
  logic               grant1;
  logic               slot_free;
  logic               accept;
  logic               last;
  logic [SHAMT_W-1:0] op_a;
  logic [DATA_W-1:0]  op_b;
  logic [1:0]         op_ft;
  logic [DATA_W-1:0]  shift_s;

  logic               out_valid_q;
  logic [DATA_W-1:0]  out_s_q;
  logic               out_id_q;
  logic               out_err_q;

  always_comb begin
    // NOTE: defaults first, so no path through this block can infer a latch.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      // Contested: round-robin hands the slot to whoever did not win last.
      if (RR_ENABLE && (last == REQ_ALU)) grant1 = 1'b1;
      else                                grant0 = 1'b1;
    end else if (bus.req0_valid) begin
      grant0 = 1'b1;
    end else if (bus.req1_valid) begin
      grant1 = 1'b1;
    end
  end

  assign slot_free      = !out_valid_q || bus.out_ready;
  assign bus.req0_ready = grant0 && slot_free;
  assign bus.req1_ready = grant1 && slot_free;
  assign accept         = (grant0 || grant1) && slot_free;

  assign op_a  = grant1 ? bus.req1_a  : bus.req0_a;
  assign op_b  = grant1 ? bus.req1_b  : bus.req0_b;
  assign op_ft = grant1 ? bus.req1_ft : bus.req0_ft;

  Shift u_shift (
    .A  (op_a),
    .B  (op_b),
    .FT (op_ft),
    .S  (shift_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments; the data fields are
    // reset too so a dropped result never leaks out after reset.
    if (reset) begin
      out_valid_q <= 1'b0;
      out_s_q     <= '0;
      out_id_q    <= REQ_ALU;
      out_err_q   <= 1'b0;
      last        <= REQ_ALIGN;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_s_q     <= (op_ft == FT_ILLEGAL) ? '0 : shift_s;
      out_id_q    <= grant1;
      out_err_q   <= (op_ft == FT_ILLEGAL);
      last        <= grant1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_s     = out_s_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_err   = out_err_q;

endmodule
